// File: rtl/router_pkg.sv
// router_pkg: shared flit/VC types and link bus layout for router output units.
package router_pkg;
  localparam int DEF_FLIT_W = 32;
  localparam int DEF_NUM_VC = 4;
  localparam int DEF_BUF_DEPTH = 4;
  localparam int DEF_VC_W = $clog2(DEF_NUM_VC);
  typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_type_t;
  typedef enum logic {VC_IDLE = 1'b0, VC_ACTIVE = 1'b1} vc_state_t;
  typedef struct packed {
    logic                  valid;
    flit_type_t            ftype;
    logic [DEF_VC_W-1:0]   vc;
    logic [DEF_FLIT_W-1:0] flit;
  } link_bus_t;
  function automatic logic opens_packet(flit_type_t t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction
endpackage

// File: rtl/output_vc_tracker.sv
// output_vc_tracker: one downstream VC's ownership state and credit counter.
module output_vc_tracker
  import router_pkg::*;
#(
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       accept,
  input  flit_type_t flit_type,
  input  logic       credit_ret,
  output vc_state_t  state,
  output logic       has_credit,
  output logic       overflow
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
  logic [CNT_W-1:0] cnt;
  logic full;
  assign full = (cnt == FULL);
  assign has_credit = (cnt != '0);
  // A return to an already-full counter is a downstream protocol violation.
  assign overflow = credit_ret & ~accept & full;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= VC_IDLE;
      cnt <= FULL;
    end else begin
      if (accept)
        state <= (flit_type == HEAD) ? VC_ACTIVE : (flit_type == TAIL) ? VC_IDLE : state;
      if (accept && !credit_ret)
        cnt <= cnt - CNT_W'(1);
      else if (credit_ret && !accept && !full)
        cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/output_unit_vc.sv
// output_unit_vc: router output port with per-VC ownership, credit flow control and a registered link stage.
module output_unit_vc
  import router_pkg::*;
#(
  parameter int FLIT_W = DEF_FLIT_W,
  parameter int NUM_VC = DEF_NUM_VC,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int VC_W = $clog2(NUM_VC),
  parameter int CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_sw_valid,
  input  logic [FLIT_W-1:0] i_sw_flit,
  input  flit_type_t        i_sw_type,
  input  logic [VC_W-1:0]   i_sw_vc,
  output logic              o_sw_ack,
  input  logic              i_credit_valid,
  input  logic [VC_W-1:0]   i_credit_vc,
  output logic              o_link_valid,
  output logic [FLIT_W-1:0] o_link_flit,
  output flit_type_t        o_link_type,
  output logic [VC_W-1:0]   o_link_vc,
  output logic [NUM_VC-1:0] o_vc_free,
  output logic [NUM_VC-1:0] o_vc_credit,
  output logic              o_err
);
  vc_state_t st [NUM_VC];
  logic [NUM_VC-1:0] ovf;
  logic legal, illegal, err;
  link_bus_t link_q;
  for (genvar v = 0; v < NUM_VC; v++) begin : gen_vc
    output_vc_tracker #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_trk (
      .clk       (clk),
      .reset_n   (reset_n),
      .accept    (o_sw_ack && (i_sw_vc == VC_W'(v))),
      .flit_type (i_sw_type),
      .credit_ret(i_credit_valid && (i_credit_vc == VC_W'(v))),
      .state     (st[v]),
      .has_credit(o_vc_credit[v]),
      .overflow  (ovf[v])
    );
    assign o_vc_free[v] = (st[v] == VC_IDLE);
  end
  always_comb begin
    legal = opens_packet(i_sw_type) ? (st[i_sw_vc] == VC_IDLE) : (st[i_sw_vc] == VC_ACTIVE);
    o_sw_ack = i_sw_valid & o_vc_credit[i_sw_vc] & legal;
    // Only a flit that would otherwise have been sent counts as a protocol error.
    illegal = i_sw_valid & o_vc_credit[i_sw_vc] & ~legal;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      link_q <= '0;
      err <= 1'b0;
    end else begin
      link_q.valid <= o_sw_ack;
      if (o_sw_ack) begin
        link_q.ftype <= i_sw_type;
        link_q.vc <= i_sw_vc;
        link_q.flit <= i_sw_flit;
      end
      err <= err | illegal | (|ovf);
    end
  end
  assign o_link_valid = link_q.valid;
  assign o_link_flit = link_q.flit;
  assign o_link_type = link_q.ftype;
  assign o_link_vc = link_q.vc;
  assign o_err = err;
endmodule

// File: tb/tb_output_unit_vc.sv
// tb_output_unit_vc: directed checks of acceptance, credits, link timing, errors and reset.
module tb_output_unit_vc;
  import router_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0;
  logic sw_valid = 1'b0, credit_valid = 1'b0;
  logic [31:0] sw_flit = '0;
  flit_type_t sw_type = HEAD;
  logic [1:0] sw_vc = '0, credit_vc = '0;
  logic sw_ack, link_valid, err;
  logic [31:0] link_flit;
  flit_type_t link_type;
  logic [1:0] link_vc;
  logic [3:0] vc_free, vc_credit;
  int total = 0, bad = 0;

  output_unit_vc dut (
    .clk(clk), .reset_n(reset_n),
    .i_sw_valid(sw_valid), .i_sw_flit(sw_flit), .i_sw_type(sw_type), .i_sw_vc(sw_vc),
    .o_sw_ack(sw_ack), .i_credit_valid(credit_valid), .i_credit_vc(credit_vc),
    .o_link_valid(link_valid), .o_link_flit(link_flit), .o_link_type(link_type),
    .o_link_vc(link_vc), .o_vc_free(vc_free), .o_vc_credit(vc_credit), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] vc, input flit_type_t t, input logic [31:0] f,
                       input logic cv = 1'b0, input logic [1:0] cvc = 2'd0);
    sw_valid = v; sw_vc = vc; sw_type = t; sw_flit = f;
    credit_valid = cv; credit_vc = cvc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [1:0] vc, input flit_type_t t, input logic [31:0] f,
                      input logic exp_ack, input logic cv = 1'b0, input logic [1:0] cvc = 2'd0);
    drive(1'b1, vc, t, f, cv, cvc);
    chk({tag, "_ack"}, sw_ack, exp_ack);
    tick;
    chk({tag, "_lv"}, link_valid, exp_ack);
    if (exp_ack) begin
      chk({tag, "_lf"}, link_flit, f);
      chk({tag, "_lvc"}, link_vc, vc);
      chk({tag, "_lt"}, link_type, t);
    end
  endtask

  task automatic idle;
    drive(1'b0, 2'd0, HEAD, 32'h0);
  endtask

  task automatic do_reset;
    idle;
    reset_n = 1'b0;
    #1;
    chk("rst_lv", link_valid, 1'b0);
    chk("rst_free", vc_free, 4'b1111);
    chk("rst_cred", vc_credit, 4'b1111);
    chk("rst_err", err, 1'b0);
    chk("rst_lf", link_flit, 32'h0);
    reset_n = 1'b1;
    tick;
    chk("post_rst_lv", link_valid, 1'b0);
  endtask

  initial begin
    #12;
    chk("init_lv", link_valid, 1'b0);
    chk("init_free", vc_free, 4'b1111);
    chk("init_cred", vc_credit, 4'b1111);
    chk("init_err", err, 1'b0);
    reset_n = 1'b1;
    tick;

    // H,B,T on VC1
    send("p1_h", 2'd1, HEAD, 32'hA0, 1'b1);
    chk("p1_free_h", vc_free, 4'b1101);
    send("p1_b", 2'd1, BODY, 32'hA1, 1'b1);
    chk("p1_free_b", vc_free, 4'b1101);
    send("p1_t", 2'd1, TAIL, 32'hA2, 1'b1);
    chk("p1_free_t", vc_free, 4'b1111);
    chk("p1_cred", vc_credit, 4'b1111);
    send("p1_ht", 2'd1, HEADTAIL, 32'hA3, 1'b1);
    chk("p1_cred0", vc_credit, 4'b1101);
    chk("p1_free_ht", vc_free, 4'b1111);
    send("p1_nocr", 2'd1, HEADTAIL, 32'hA4, 1'b0);
    chk("p1_hold", link_flit, 32'hA3);
    chk("p1_err", err, 1'b0);

    // credit exhaustion on VC0
    send("p2_0", 2'd0, HEAD, 32'hB0, 1'b1);
    send("p2_1", 2'd0, BODY, 32'hB1, 1'b1);
    send("p2_2", 2'd0, BODY, 32'hB2, 1'b1);
    send("p2_3", 2'd0, BODY, 32'hB3, 1'b1);
    chk("p2_cred", vc_credit, 4'b1100);
    send("p2_4held", 2'd0, TAIL, 32'hB4, 1'b0);
    chk("p2_err", err, 1'b0);
    send("p2_4ret", 2'd0, TAIL, 32'hB4, 1'b0, 1'b1, 2'd0);
    send("p2_4go", 2'd0, TAIL, 32'hB4, 1'b1);
    chk("p2_free", vc_free, 4'b1111);
    chk("p2_cred_end", vc_credit, 4'b1100);

    // simultaneous send/return on VC2, cross-VC independence with VC3
    send("p3_h", 2'd2, HEAD, 32'hC0, 1'b1);
    send("p3_b", 2'd2, BODY, 32'hC1, 1'b1);
    send("p3_same", 2'd2, BODY, 32'hC2, 1'b1, 1'b1, 2'd2);
    send("p3_x", 2'd3, HEAD, 32'hD0, 1'b1, 1'b1, 2'd2);
    send("p3_c2a", 2'd2, BODY, 32'hC3, 1'b1);
    send("p3_c2b", 2'd2, BODY, 32'hC4, 1'b1);
    chk("p3_vc2_1", vc_credit[2], 1'b1);
    send("p3_c2c", 2'd2, TAIL, 32'hC5, 1'b1);
    chk("p3_vc2_0", vc_credit[2], 1'b0);
    send("p3_d1", 2'd3, BODY, 32'hD1, 1'b1);
    send("p3_d2", 2'd3, BODY, 32'hD2, 1'b1);
    chk("p3_vc3_1", vc_credit[3], 1'b1);
    send("p3_d3", 2'd3, TAIL, 32'hD3, 1'b1);
    chk("p3_vc3_0", vc_credit[3], 1'b0);
    chk("p3_free", vc_free, 4'b1111);
    chk("p3_err", err, 1'b0);

    // BODY to idle VC0
    drive(1'b0, 2'd0, HEAD, 32'h0, 1'b1, 2'd0);
    tick;
    chk("p4_cr0", vc_credit[0], 1'b1);
    send("p4_ill", 2'd0, BODY, 32'hE0, 1'b0);
    chk("p4_err", err, 1'b1);
    chk("p4_free", vc_free, 4'b1111);
    chk("p4_cr0_keep", vc_credit[0], 1'b1);
    idle;
    tick;
    tick;
    chk("p4_sticky", err, 1'b1);

    // credit overflow after reset
    do_reset;
    drive(1'b0, 2'd0, HEAD, 32'h0, 1'b1, 2'd0);
    chk("p5_noack", sw_ack, 1'b0);
    tick;
    chk("p5_err", err, 1'b1);
    send("p5_0", 2'd0, HEADTAIL, 32'hF0, 1'b1);
    send("p5_1", 2'd0, HEADTAIL, 32'hF1, 1'b1);
    send("p5_2", 2'd0, HEADTAIL, 32'hF2, 1'b1);
    chk("p5_cr1", vc_credit[0], 1'b1);
    send("p5_3", 2'd0, HEADTAIL, 32'hF3, 1'b1);
    chk("p5_cr0", vc_credit[0], 1'b0);

    // reset mid-packet on VC1
    do_reset;
    send("p6_h", 2'd1, HEAD, 32'h60, 1'b1);
    send("p6_b", 2'd1, BODY, 32'h61, 1'b1);
    chk("p6_busy", vc_free, 4'b1101);
    do_reset;
    chk("p6_err", err, 1'b0);
    send("p6_body_idle", 2'd1, BODY, 32'h62, 1'b0);
    do_reset;
    send("p6_nh", 2'd1, HEAD, 32'h70, 1'b1);
    send("p6_nb1", 2'd1, BODY, 32'h71, 1'b1);
    send("p6_nb2", 2'd1, BODY, 32'h72, 1'b1);
    chk("p6_cr1", vc_credit[1], 1'b1);
    send("p6_nb3", 2'd1, BODY, 32'h73, 1'b1);
    chk("p6_cr0", vc_credit[1], 1'b0);
    idle;
    tick;
    chk("p6_idle_lv", link_valid, 1'b0);
    chk("p6_hold", link_flit, 32'h73);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
